// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit.
//   IF_ADDR_W / IF_DATA_W : default PC and instruction-byte widths
//   fetch_state_t         : fetch sequencer states (ISSUE, WAIT, CAPTURE)
//   fifo_entry_t          : one prefetch FIFO entry {pc, instr}
package if_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 8;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding fetched {pc, instr} entries until decode accepts them.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   wr_entry   : entry to write
//   head       : current head entry (registered storage, holds while not popped)
//   full/empty : occupancy flags
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t wr_entry,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t      mem_q [DEPTH];
  fifo_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leave the count unchanged.
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, drives the instruction-memory address,
// waits out the memory access time, captures each byte into a prefetch FIFO and
// presents the FIFO head to decode over a valid/ready handshake.
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   ABUS / DATABUS        : instruction memory address out / data in
//   BR_TAKEN, BR_TARGET   : redirect pulse and target (flushes prefetched bytes)
//   HALT                  : level, blocks new fetches while high
//   INSTR, INSTR_PC       : FIFO head byte and the address it came from
//   INSTR_VALID/READY     : decode handshake
//   FETCH_CNT             : saturating count of captured bytes (IF_PERF_CNT_EN only)
// Build option: define IF_PERF_CNT_EN to add the FETCH_CNT port and counter.
// ADDR_W / DATA_W must match IF_ADDR_W / IF_DATA_W of if_pkg (FIFO entry layout).
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W       = IF_ADDR_W,
  parameter int                DATA_W       = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                MEM_WAIT_CYC = 2,
  parameter int                FIFO_DEPTH   = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DATABUS,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  input  logic              HALT,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       FETCH_CNT
`endif
);

  localparam int                WCNT_W    = (MEM_WAIT_CYC > 1) ? $clog2(MEM_WAIT_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_WAIT_CYC - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] abus_q, abus_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              push, flush, pop;
  logic              fifo_full, fifo_empty;
  fifo_entry_t       wr_entry, head;

  assign wr_entry    = '{pc: pc_q, instr: DATABUS};
  // A redirect flushes, so a pop in the same cycle must not consume anything.
  assign pop         = INSTR_READY && !BR_TAKEN;
  assign ABUS        = abus_q;
  assign INSTR       = head.instr;
  assign INSTR_PC    = head.pc;
  assign INSTR_VALID = !fifo_empty;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    abus_d  = abus_q;
    wcnt_d  = wcnt_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (BR_TAKEN) begin
      // Redirect wins from any state; an in-flight fetch is abandoned.
      flush   = 1'b1;
      pc_d    = BR_TARGET;
      wcnt_d  = '0;
      state_d = ISSUE;
    end else begin
      case (state_q)
        ISSUE: begin
          // ABUS follows PC while parked here, so a stalled fetch shows its address.
          abus_d = pc_q;
          wcnt_d = '0;
          if (!fifo_full && !HALT) state_d = WAIT;
        end
        WAIT: begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_LAST) state_d = CAPTURE;
        end
        CAPTURE: begin
          push    = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      abus_q  <= RESET_PC;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      abus_q  <= abus_d;
      wcnt_q  <= wcnt_d;
    end
  end

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  // Counts completed captures only; redirects do not clear it.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (push && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) fetch_cnt_q <= '0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end

  assign FETCH_CNT = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle table after reset, directed
// corner-case sequences, and a randomized run against a stream-level model.
module tb_instr_fetch_unit;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] ABUS, DATABUS, BR_TARGET, INSTR, INSTR_PC;
  logic       BR_TAKEN, HALT, INSTR_VALID, INSTR_READY;
  logic [7:0] ABUS2, DATABUS2, INSTR2, INSTR_PC2;
  logic       INSTR_VALID2;
`ifdef IF_PERF_CNT_EN
  logic [15:0] FETCH_CNT, FETCH_CNT2;
`endif

  logic [7:0] im [256];
  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  assign DATABUS  = im[ABUS];
  assign DATABUS2 = im[ABUS2];

  instr_fetch_unit u_dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ABUS        (ABUS),
    .DATABUS     (DATABUS),
    .BR_TAKEN    (BR_TAKEN),
    .BR_TARGET   (BR_TARGET),
    .HALT        (HALT),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY)
`ifdef IF_PERF_CNT_EN
    ,
    .FETCH_CNT   (FETCH_CNT)
`endif
  );

  instr_fetch_unit #(
    .RESET_PC (8'hFE)
  ) u_dut_fe (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ABUS        (ABUS2),
    .DATABUS     (DATABUS2),
    .BR_TAKEN    (1'b0),
    .BR_TARGET   (8'h00),
    .HALT        (1'b0),
    .INSTR       (INSTR2),
    .INSTR_PC    (INSTR_PC2),
    .INSTR_VALID (INSTR_VALID2),
    .INSTR_READY (1'b1)
`ifdef IF_PERF_CNT_EN
    ,
    .FETCH_CNT   (FETCH_CNT2)
`endif
  );

  typedef struct {
    logic       rdy;
    logic       valid;
    logic [7:0] abus;
    logic       chkd;
    logic [7:0] pc;
    logic [7:0] ins;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Holds reset for two edges; returns just after release ("cycle 0").
  task automatic do_reset();
    RST_N    = 1'b0;
    BR_TAKEN = 1'b0;
    HALT     = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  // Waits (bounded) for a valid head, checks it, then lets one edge consume it.
  task automatic take(input string nm, input logic [7:0] epc, input logic [7:0] eins);
    int n = 0;
    while (!INSTR_VALID && n < 60) begin
      step();
      n++;
    end
    if (!INSTR_VALID) begin
      chk({nm, " timeout"}, 0, 1);
    end else begin
      chk({nm, " pc"}, int'(INSTR_PC), int'(epc));
      chk({nm, " instr"}, int'(INSTR), int'(eins));
    end
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] q_pc[$];
    logic [7:0] q_ins[$];
    logic [7:0] exp_pc, hold_pc, hold_ins;
    logic       prev_hold, prev_br;
    int         seen, accepted;

    for (int i = 0; i < 256; i++) im[i] = 8'(i * 7 + 3);
    im[0] = 8'hA1; im[1] = 8'hB2; im[2] = 8'hC3; im[3] = 8'hD4;

    tbl = '{
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 8'hA1},
      '{1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 8'hB2},
      '{1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 8'h00},
      '{1'b1, 1'b1, 8'h02, 1'b1, 8'h02, 8'hC3}
    };

    BR_TAKEN = 1'b0; BR_TARGET = 8'h00; HALT = 1'b0; INSTR_READY = 1'b1;

    // Test 1: cycle-by-cycle after reset, READY high.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k > 0) step();
      chk($sformatf("t1 c%0d valid", k), int'(INSTR_VALID), int'(tbl[k].valid));
      chk($sformatf("t1 c%0d abus", k), int'(ABUS), int'(tbl[k].abus));
      if (tbl[k].chkd) begin
        chk($sformatf("t1 c%0d pc", k), int'(INSTR_PC), int'(tbl[k].pc));
        chk($sformatf("t1 c%0d instr", k), int'(INSTR), int'(tbl[k].ins));
      end
      INSTR_READY = tbl[k].rdy;
    end
`ifdef IF_PERF_CNT_EN
    chk("t1 fetch_cnt", int'(FETCH_CNT), 3);
`endif

    // Test 2: decode stalled; FIFO fills, fetch of 02 parks in ISSUE.
    INSTR_READY = 1'b0;
    do_reset();
    repeat (20) step();
    chk("t2 valid", int'(INSTR_VALID), 1);
    chk("t2 abus", int'(ABUS), 8'h02);
    chk("t2 head pc", int'(INSTR_PC), 8'h00);
    chk("t2 head instr", int'(INSTR), 8'hA1);
    INSTR_READY = 1'b1;
    take("t2 b0", 8'h00, 8'hA1);
    take("t2 b1", 8'h01, 8'hB2);
    take("t2 b2", 8'h02, 8'hC3);

    // Test 3: redirect during WAIT of 01 with A1 still queued.
    INSTR_READY = 1'b0;
    do_reset();
    repeat (5) step();
    chk("t3 pre valid", int'(INSTR_VALID), 1);
    chk("t3 pre abus", int'(ABUS), 8'h01);
    BR_TAKEN = 1'b1; BR_TARGET = 8'h40; INSTR_READY = 1'b1;
    step();
    BR_TAKEN = 1'b0; INSTR_READY = 1'b0;
    chk("t3 flush valid", int'(INSTR_VALID), 0);
    step();
    chk("t3 abus", int'(ABUS), 8'h40);
    INSTR_READY = 1'b1;
    take("t3 target", 8'h40, im[8'h40]);

    // Test 4: RESET_PC=FE instance wraps through FF to 00.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (INSTR_VALID2) begin
        q_pc.push_back(INSTR_PC2);
        q_ins.push_back(INSTR2);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] epc;
      epc = 8'(8'hFE + i);
      if (i < q_pc.size()) begin
        chk($sformatf("t4 b%0d pc", i), int'(q_pc[i]), int'(epc));
        chk($sformatf("t4 b%0d instr", i), int'(q_ins[i]), int'(im[epc]));
      end else begin
        chk($sformatf("t4 b%0d missing", i), -1, int'(epc));
      end
    end

    // Test 5: HALT raised while 00 is in WAIT.
    INSTR_READY = 1'b1;
    do_reset();
    step();
    step();
    HALT = 1'b1;
    take("t5 inflight", 8'h00, 8'hA1);
    seen = 0;
    repeat (20) begin
      if (INSTR_VALID) seen++;
      step();
    end
    chk("t5 halted valids", seen, 0);
    chk("t5 halted abus", int'(ABUS), 8'h01);
    HALT = 1'b0;
    take("t5 resume", 8'h01, 8'hB2);

    // Test 6: asynchronous reset mid-WAIT.
    INSTR_READY = 1'b0;
    do_reset();
    repeat (6) step();
    chk("t6 pre valid", int'(INSTR_VALID), 1);
    RST_N = 1'b0;
    #1;
    chk("t6 rst valid", int'(INSTR_VALID), 0);
    chk("t6 rst instr", int'(INSTR), 0);
    chk("t6 rst pc", int'(INSTR_PC), 0);
    chk("t6 rst abus", int'(ABUS), 0);
`ifdef IF_PERF_CNT_EN
    chk("t6 rst fetch_cnt", int'(FETCH_CNT), 0);
`endif
    step();
    RST_N = 1'b1;
    INSTR_READY = 1'b1;
    take("t6 restart b0", 8'h00, 8'hA1);
    take("t6 restart b1", 8'h01, 8'hB2);

    // Random: delivered stream must be consecutive addresses from the last
    // redirect target (or reset PC), each carrying its memory byte.
    INSTR_READY = 1'b0;
    do_reset();
    exp_pc = 8'h00; accepted = 0; prev_hold = 1'b0; prev_br = 1'b0;
    hold_pc = 8'h00; hold_ins = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (prev_br) chk("rnd flush valid", int'(INSTR_VALID), 0);
      if (prev_hold) begin
        chk("rnd hold valid", int'(INSTR_VALID), 1);
        chk("rnd hold pc", int'(INSTR_PC), int'(hold_pc));
        chk("rnd hold instr", int'(INSTR), int'(hold_ins));
      end
      BR_TAKEN    = ($urandom_range(0, 99) < 3);
      BR_TARGET   = 8'($urandom);
      INSTR_READY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) HALT = ~HALT;
      if (BR_TAKEN) begin
        exp_pc = BR_TARGET;
      end else if (INSTR_VALID && INSTR_READY) begin
        chk("rnd pc", int'(INSTR_PC), int'(exp_pc));
        chk("rnd instr", int'(INSTR), int'(im[exp_pc]));
        exp_pc = exp_pc + 8'd1;
        accepted++;
      end
      prev_hold = INSTR_VALID && !INSTR_READY && !BR_TAKEN;
      hold_pc   = INSTR_PC;
      hold_ins  = INSTR;
      prev_br   = BR_TAKEN;
      step();
    end
    BR_TAKEN = 1'b0; HALT = 1'b0;
    chk("rnd progress", int'(accepted >= 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
